// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the combinational alu and its sequential front end.
//   - 4-bit alu_op encodings OP_ADD..OP_OR
//   - is_fp_op(op)    : 1 for the float class (selects FP latency)
//   - is_valid_op(op) : 1 for defined encodings 0000-1001
//   - state_e         : request/execute/response FSM states
package alu_pkg;

    localparam logic [3:0] OP_ADD          = 4'b0000;
    localparam logic [3:0] OP_SUB          = 4'b0001;
    localparam logic [3:0] OP_MUL          = 4'b0010;
    localparam logic [3:0] OP_SHL          = 4'b0011;
    localparam logic [3:0] OP_SHR          = 4'b0100;
    localparam logic [3:0] OP_FMUL         = 4'b0101;
    localparam logic [3:0] OP_FLOOR        = 4'b0110;
    localparam logic [3:0] OP_FLOOR_TO_INT = 4'b0111;
    localparam logic [3:0] OP_FCMP         = 4'b1000;
    localparam logic [3:0] OP_OR           = 4'b1001;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StExec = 2'b01,
        StResp = 2'b10
    } state_e;

    function automatic logic is_fp_op(logic [3:0] op);
        return (op == OP_FMUL) || (op == OP_FLOOR) || (op == OP_FLOOR_TO_INT) ||
               (op == OP_FCMP);
    endfunction

    function automatic logic is_valid_op(logic [3:0] op);
        return op <= OP_OR;
    endfunction

endpackage

// File: rtl/alu.sv
// alu: combinational 32-bit integer / single-precision float unit.
// Ports:
//   a, b    : 32-bit operands
//   alu_op  : 4-bit operation select (see alu_pkg)
//   result  : 32-bit result; 0 for undefined encodings
// Float handling is simplified: denormal inputs flush to zero, FMUL truncates,
// Inf/NaN inputs to FMUL give a quiet NaN, FCMP returns 1 when a < b.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_op,
    output logic [31:0] result
);

    logic [7:0]  ea;
    logic [7:0]  eb;
    logic [47:0] prod;
    logic [9:0]  esum;
    logic [9:0]  eout;
    logic [31:0] fmul_res;
    logic [7:0]  fsh;
    logic [30:0] fmask;
    logic [31:0] floor_res;
    logic [31:0] int_mag;
    logic [31:0] frac_mask;
    logic        frac_nz;
    logic [31:0] fti_res;
    logic        fcmp_lt;
    logic        unused_bits;

    assign ea = a[30:23];
    assign eb = b[30:23];

    // FMUL: 24x24 mantissa product, one-bit normalisation, truncation.
    always_comb begin
        prod     = {1'b1, a[22:0]} * {1'b1, b[22:0]};
        esum     = {2'b00, ea} + {2'b00, eb} + {9'b0, prod[47]};
        eout     = esum - 10'd127;
        fmul_res = 32'h0;
        if (ea == 8'hFF || eb == 8'hFF) begin
            fmul_res = 32'h7FC0_0000;
        end else if (ea == 8'h00 || eb == 8'h00 || esum <= 10'd127) begin
            fmul_res = {a[31] ^ b[31], 31'b0};
        end else if (esum >= 10'd382) begin
            fmul_res = {a[31] ^ b[31], 8'hFF, 23'b0};
        end else begin
            fmul_res = {a[31] ^ b[31], eout[7:0], prod[47] ? prod[46:24] : prod[45:23]};
        end
    end

    // FLOOR (float -> float). Clearing the fractional field bits truncates toward zero;
    // negatives with a fraction then step one unit away, carrying into the exponent.
    always_comb begin
        fsh       = 8'd150 - ea;
        fmask     = (31'd1 << fsh) - 31'd1;
        floor_res = a;
        if (ea < 8'd127) begin
            floor_res = (a[31] && a[30:0] != 31'b0) ? 32'hBF80_0000 : {a[31], 31'b0};
        end else if (ea < 8'd150 && (a[30:0] & fmask) != 31'b0) begin
            floor_res = a[31] ? {1'b1, (a[30:0] & ~fmask) + (31'd1 << fsh)}
                              : {1'b0, a[30:0] & ~fmask};
        end
    end

    // FLOOR_TO_INT (float -> signed int32), saturating out of range.
    always_comb begin
        frac_mask = (32'd1 << fsh) - 32'd1;
        int_mag   = 32'h0;
        frac_nz   = 1'b0;
        if (ea >= 8'd150) begin
            int_mag = {8'b0, 1'b1, a[22:0]} << (ea - 8'd150);
        end else begin
            int_mag = {8'b0, 1'b1, a[22:0]} >> fsh;
            frac_nz = ({8'b0, 1'b1, a[22:0]} & frac_mask) != 32'h0;
        end
        if (ea < 8'd127) begin
            fti_res = (a[31] && a[30:0] != 31'b0) ? 32'hFFFF_FFFF : 32'h0;
        end else if (ea >= 8'd158) begin
            fti_res = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else begin
            fti_res = a[31] ? -(int_mag + {31'b0, frac_nz}) : int_mag;
        end
    end

    // FCMP: sign-magnitude less-than; +0 and -0 compare equal.
    always_comb begin
        if (a[30:0] == 31'b0 && b[30:0] == 31'b0) begin
            fcmp_lt = 1'b0;
        end else if (a[31] != b[31]) begin
            fcmp_lt = a[31];
        end else if (a[31]) begin
            fcmp_lt = a[30:0] > b[30:0];
        end else begin
            fcmp_lt = a[30:0] < b[30:0];
        end
    end

    always_comb begin
        unique case (alu_op)
            OP_ADD:          result = a + b;
            OP_SUB:          result = a - b;
            OP_MUL:          result = a * b;
            OP_SHL:          result = a << b[4:0];
            OP_SHR:          result = a >> b[4:0];
            OP_FMUL:         result = fmul_res;
            OP_FLOOR:        result = floor_res;
            OP_FLOOR_TO_INT: result = fti_res;
            OP_FCMP:         result = {31'b0, fcmp_lt};
            OP_OR:           result = a | b;
            default:         result = 32'h0;
        endcase
    end

    assign unused_bits = ^{prod[22:0], eout[9:8]};

endmodule

// File: rtl/alu_seq.sv
// alu_seq: valid/ready request/response front end for the combinational alu.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   in_valid/in_ready        : request handshake; in_a, in_b, in_op request payload
//   out_valid/out_ready      : response handshake; out_result, out_invalid payload
//   stat_ops, stat_invalid   : response / invalid-response counters
//                              (present only with ALU_SEQ_STATS_EN defined)
// Parameters: INT_LAT / FP_LAT (1..15) cycles from accept to result capture.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned INT_LAT = 1,
    parameter int unsigned FP_LAT  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [3:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_invalid
`ifdef ALU_SEQ_STATS_EN
    ,
    output logic [31:0] stat_ops,
    output logic [31:0] stat_invalid
`endif
);

    localparam logic [3:0] IntCnt = 4'(INT_LAT - 1);
    localparam logic [3:0] FpCnt  = 4'(FP_LAT - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [3:0]  op_q;
    logic        out_valid_q;
    logic [31:0] out_result_q;
    logic        out_invalid_q;
    logic [31:0] alu_result;

    // Operands reach the alu only from the latched registers.
    alu u_alu (
        .a      (a_q),
        .b      (b_q),
        .alu_op (op_q),
        .result (alu_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            cnt_q         <= 4'd0;
            a_q           <= 32'h0;
            b_q           <= 32'h0;
            op_q          <= 4'd0;
            out_valid_q   <= 1'b0;
            out_result_q  <= 32'h0;
            out_invalid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q     <= in_a;
                        b_q     <= in_b;
                        op_q    <= in_op;
                        cnt_q   <= is_fp_op(in_op) ? FpCnt : IntCnt;
                        state_q <= StExec;
                    end
                end
                StExec: begin
                    if (cnt_q == 4'd0) begin
                        out_result_q  <= alu_result;
                        out_invalid_q <= !is_valid_op(op_q);
                        out_valid_q   <= 1'b1;
                        state_q       <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef ALU_SEQ_STATS_EN
    logic [31:0] stat_ops_q;
    logic [31:0] stat_invalid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops_q     <= 32'h0;
            stat_invalid_q <= 32'h0;
        end else if (out_valid_q && out_ready) begin
            stat_ops_q <= stat_ops_q + 32'd1;
            if (out_invalid_q) begin
                stat_invalid_q <= stat_invalid_q + 32'd1;
            end
        end
    end

    assign stat_ops     = stat_ops_q;
    assign stat_invalid = stat_invalid_q;
`endif

    assign in_ready    = (state_q == StIdle);
    assign out_valid   = out_valid_q;
    assign out_result  = out_result_q;
    assign out_invalid = out_invalid_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with default latencies (INT 1, FP 3).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [3:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_invalid;
`ifdef ALU_SEQ_STATS_EN
    logic [31:0] stat_ops;
    logic [31:0] stat_invalid;
`endif

    int tests = 0;
    int fails = 0;
    logic [31:0] hs_q[$];

    always #5 clk = ~clk;

    alu_seq dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_op       (in_op),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
`ifdef ALU_SEQ_STATS_EN
        .stat_ops    (stat_ops),
        .stat_invalid(stat_invalid),
`endif
        .out_invalid (out_invalid)
    );

    // Record every response handshake in order.
    always @(posedge clk) begin
        if (out_valid && out_ready) hs_q.push_back(out_result);
    end

    task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) begin
            tests++; fails++;
            $display("FAIL send_req_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycles from accept edge until out_valid; -1 on timeout.
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b0;
        #3;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        tests++; if (out_result !== 32'h0) begin fails++; $display("FAIL reset_out_result: got %h required 0", out_result); end
        tests++; if (out_invalid !== 1'b0) begin fails++; $display("FAIL reset_out_invalid: got %b required 0", out_invalid); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
`ifdef ALU_SEQ_STATS_EN
        tests++; if (stat_ops !== 32'h0) begin fails++; $display("FAIL reset_stat_ops: got %0d required 0", stat_ops); end
`endif
    endtask

    task automatic test_add();
        int lat;
        out_ready = 1'b1;
        send_req(32'd10, 32'd20, 4'b0000);
        wait_valid(lat);
        tests++; if (lat != 1) begin fails++; $display("FAIL add_latency: got %0d required 1", lat); end
        tests++; if (out_result !== 32'd30) begin fails++; $display("FAIL add_result: got %h required 0000001e", out_result); end
        tests++; if (out_invalid !== 1'b0) begin fails++; $display("FAIL add_invalid: got %b required 0", out_invalid); end
        @(posedge clk); #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL add_ready_return: got %b required 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL add_valid_drop: got %b required 0", out_valid); end
    endtask

    task automatic test_fp();
        int lat;
        out_ready = 1'b1;
        send_req(32'h4020_0000, 32'h4080_0000, 4'b0101);
        in_a = 32'hDEAD_BEEF; in_b = 32'h1234_5678; in_op = 4'b0000;
        wait_valid(lat);
        tests++; if (lat != 3) begin fails++; $display("FAIL fmul_latency: got %0d required 3", lat); end
        tests++; if (out_result !== 32'h4120_0000) begin fails++; $display("FAIL fmul_result: got %h required 41200000", out_result); end
        send_req(32'hBE99_999A, 32'h0, 4'b0111);
        wait_valid(lat);
        tests++; if (lat != 3) begin fails++; $display("FAIL fti_latency: got %0d required 3", lat); end
        tests++; if (out_result !== 32'hFFFF_FFFF) begin fails++; $display("FAIL fti_result: got %h required ffffffff", out_result); end
        send_req(32'hC020_0000, 32'h0, 4'b0110);
        wait_valid(lat);
        tests++; if (out_result !== 32'hC040_0000) begin fails++; $display("FAIL floor_result: got %h required c0400000", out_result); end
        send_req(32'h3F80_0000, 32'h4000_0000, 4'b1000);
        wait_valid(lat);
        tests++; if (out_result !== 32'h1) begin fails++; $display("FAIL fcmp_result: got %h required 00000001", out_result); end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        out_ready = 1'b0;
        send_req(32'd10, 32'd20, 4'b1001);
        wait_valid(lat);
        tests++; if (lat != 1) begin fails++; $display("FAIL bp_latency: got %0d required 1", lat); end
        in_valid = 1'b1; in_a = 32'd1; in_b = 32'd1; in_op = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid_hold[%0d]: got %b required 1", i, out_valid); end
            tests++; if (out_result !== 32'd30) begin fails++; $display("FAIL bp_result_hold[%0d]: got %h required 0000001e", i, out_result); end
            tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %b required 0", i, in_ready); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_complete_valid: got %b required 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_complete_ready: got %b required 1", in_ready); end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_no_accept[%0d]: in_ready got %b required 1", i, in_ready); end
        end
    endtask

    task automatic test_invalid();
        int lat;
        do_reset();
        out_ready = 1'b1;
        send_req(32'd42, 32'd24, 4'b1111);
        wait_valid(lat);
        tests++; if (lat != 1) begin fails++; $display("FAIL inv_latency: got %0d required 1", lat); end
        tests++; if (out_result !== 32'h0) begin fails++; $display("FAIL inv_result: got %h required 0", out_result); end
        tests++; if (out_invalid !== 1'b1) begin fails++; $display("FAIL inv_flag: got %b required 1", out_invalid); end
        @(posedge clk); #1;
`ifdef ALU_SEQ_STATS_EN
        tests++; if (stat_ops !== 32'd1) begin fails++; $display("FAIL inv_stat_ops: got %0d required 1", stat_ops); end
        tests++; if (stat_invalid !== 32'd1) begin fails++; $display("FAIL inv_stat_invalid: got %0d required 1", stat_invalid); end
`endif
        send_req(32'd1, 32'd2, 4'b0000);
        wait_valid(lat);
        tests++; if (out_invalid !== 1'b0) begin fails++; $display("FAIL inv_clear_flag: got %b required 0", out_invalid); end
        tests++; if (out_result !== 32'd3) begin fails++; $display("FAIL inv_next_result: got %h required 00000003", out_result); end
        @(posedge clk); #1;
`ifdef ALU_SEQ_STATS_EN
        tests++; if (stat_ops !== 32'd2) begin fails++; $display("FAIL inv_stat_ops2: got %0d required 2", stat_ops); end
        tests++; if (stat_invalid !== 32'd1) begin fails++; $display("FAIL inv_stat_invalid2: got %0d required 1", stat_invalid); end
`endif
    endtask

    task automatic test_reset_mid();
        int lat;
        logic seen;
        out_ready = 1'b1;
        send_req(32'h4020_0000, 32'h4080_0000, 4'b0101);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_exec_valid: got %b required 0", out_valid); end
        #2;
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rmid_stale_resp: got %b required 0", seen); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_in_ready: got %b required 1", in_ready); end
        // Reset while a response is being held must drop it without a clock edge.
        out_ready = 1'b0;
        send_req(32'd3, 32'd4, 4'b0000);
        wait_valid(lat);
        tests++; if (out_result !== 32'd7) begin fails++; $display("FAIL rmid_pre_result: got %h required 00000007", out_result); end
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rmid_resp_valid: got %b required 0", out_valid); end
        tests++; if (out_result !== 32'h0) begin fails++; $display("FAIL rmid_resp_result: got %h required 0", out_result); end
        #2;
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        send_req(32'd0, 32'd0, 4'b0000);
        wait_valid(lat);
        tests++; if (lat != 1) begin fails++; $display("FAIL rmid_add_latency: got %0d required 1", lat); end
        tests++; if (out_result !== 32'h0) begin fails++; $display("FAIL rmid_add_result: got %h required 0", out_result); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int lat;
        hs_q.delete();
        out_ready = 1'b1;
        send_req(32'd50, 32'd20, 4'b0001);
        wait_valid(lat);
        tests++; if (out_result !== 32'd30) begin fails++; $display("FAIL b2b_first: got %h required 0000001e", out_result); end
        send_req(32'd20, 32'd50, 4'b0001);
        wait_valid(lat);
        tests++; if (out_result !== 32'hFFFF_FFE2) begin fails++; $display("FAIL b2b_second: got %h required ffffffe2", out_result); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        tests++; if (hs_q.size() != 2) begin fails++; $display("FAIL b2b_hs_count: got %0d required 2", hs_q.size()); end
        if (hs_q.size() >= 2) begin
            tests++; if (hs_q[0] !== 32'd30) begin fails++; $display("FAIL b2b_order0: got %h required 0000001e", hs_q[0]); end
            tests++; if (hs_q[1] !== 32'hFFFF_FFE2) begin fails++; $display("FAIL b2b_order1: got %h required ffffffe2", hs_q[1]); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_fp();
        test_backpressure();
        test_invalid();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
